// File: rtl/miner_pkg.sv
// Shared widths, FSM state type and result record for the miner dispatcher.
package miner_pkg;

  localparam int HDR_W   = 608;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_EVAL     = 2'd3
  } miner_state_t;

  typedef struct packed {
    logic [HASH_W-1:0]  hash;
    logic [NONCE_W-1:0] nonce;
  } miner_result_t;

endpackage

// File: rtl/miner_dispatch_if.sv
// Bus between the dispatcher (master) and its bank of hash cores (slave).
interface miner_dispatch_if
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4
) ();

  logic [HDR_W-1:0]             core_header;
  logic [NUM_CORES-1:0]         core_start;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce;
  logic                         core_abort;
  logic [NUM_CORES-1:0]         core_done;
  logic [NUM_CORES*HASH_W-1:0]  core_hash;

  modport master (
    output core_header, core_start, core_nonce, core_abort,
    input  core_done, core_hash
  );

  modport slave (
    input  core_header, core_start, core_nonce, core_abort,
    output core_done, core_hash
  );

endinterface

// File: rtl/miner_hit_select.sv
// Flags every lane whose digest is at or below the target; the lowest lane wins.
module miner_hit_select
  import miner_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES*HASH_W-1:0] i_hash,
  input  logic [HASH_W-1:0]           i_target,
  output logic                        o_hit_any,
  output logic [IDX_W-1:0]            o_win_idx
);

  // Scan from the top lane down so the lowest hitting lane is written last.
  always_comb begin
    o_hit_any = 1'b0;
    o_win_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (i_hash[i*HASH_W +: HASH_W] <= i_target) begin
        o_hit_any = 1'b1;
        o_win_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/miner_dispatch.sv
// Job sequencer: fans one nonce per core per round, collects digests, reports
// the lowest winning nonce or the exhaustion of the nonce space.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no job; waiting for data_ready
// DISPATCH | core_start high for one cycle, nonces base..base+N-1 on bus
// WAIT     | collecting sticky per-core done flags and digests
// EVAL     | compare digests to target; report, finish, or next round
module miner_dispatch
  import miner_pkg::*;
#(
  parameter int                 NUM_CORES   = 4,
  parameter logic [NONCE_W-1:0] NONCE_START = '0
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [HDR_W+HASH_W-1:0]   rx_data,
  input  logic                      data_ready,
  output logic [HASH_W+NONCE_W-1:0] tx_data,
  output logic                      send_data,
  output logic                      exhausted,
  output logic                      busy,
  miner_dispatch_if.master          core
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  miner_state_t                 r_state;
  logic [HDR_W-1:0]             r_header;
  logic [HASH_W-1:0]            r_target;
  logic [NONCE_W:0]             r_base;
  logic [NUM_CORES-1:0]         r_flags;
  logic [NUM_CORES*HASH_W-1:0]  r_hash;
  logic [NUM_CORES-1:0]         r_start;
  logic [NUM_CORES*NONCE_W-1:0] r_nonce;
  logic                         r_abort;
  miner_result_t                r_tx;
  logic                         r_send;
  logic                         r_exh;

  logic                         w_hit_any;
  logic [IDX_W-1:0]             w_win_idx;
  logic [NONCE_W:0]             w_next_base;
  logic [NUM_CORES-1:0]         w_flags_next;
  logic [HASH_W-1:0]            w_win_hash;
  logic [NONCE_W-1:0]           w_win_nonce;

  function automatic logic [NUM_CORES*NONCE_W-1:0] lanes(input logic [NONCE_W-1:0] b);
    logic [NUM_CORES*NONCE_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CORES; i++) v[i*NONCE_W +: NONCE_W] = b + NONCE_W'(i);
    return v;
  endfunction

  miner_hit_select #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_hit (
    .i_hash    (r_hash),
    .i_target  (r_target),
    .o_hit_any (w_hit_any),
    .o_win_idx (w_win_idx)
  );

  // The extra base bit catches the carry that marks the end of the nonce space.
  assign w_next_base  = r_base + (NONCE_W+1)'(NUM_CORES);
  assign w_flags_next = r_flags | core.core_done;
  assign w_win_hash   = r_hash[int'(w_win_idx)*HASH_W +: HASH_W];
  assign w_win_nonce  = r_base[NONCE_W-1:0] + NONCE_W'(w_win_idx);

  // Job FSM; a new job always wins over whatever round is in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_IDLE;
      r_header <= '0;
      r_target <= '0;
      r_base   <= '0;
      r_flags  <= '0;
      r_hash   <= '0;
      r_start  <= '0;
      r_nonce  <= '0;
      r_abort  <= 1'b0;
      r_tx     <= '0;
      r_send   <= 1'b0;
      r_exh    <= 1'b0;
    end else begin
      r_start <= '0;
      r_abort <= 1'b0;
      r_send  <= 1'b0;
      r_exh   <= 1'b0;
      if (data_ready) begin
        r_header <= rx_data[HASH_W +: HDR_W];
        r_target <= rx_data[HASH_W-1:0];
        r_base   <= {1'b0, NONCE_START};
        r_flags  <= '0;
        r_start  <= '1;
        r_nonce  <= lanes(NONCE_START);
        r_abort  <= (r_state != ST_IDLE);
        r_state  <= ST_DISPATCH;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_DISPATCH: r_state <= ST_WAIT;
          ST_WAIT: begin
            for (int i = 0; i < NUM_CORES; i++) begin
              if (core.core_done[i] && !r_flags[i])
                r_hash[i*HASH_W +: HASH_W] <= core.core_hash[i*HASH_W +: HASH_W];
            end
            r_flags <= w_flags_next;
            if (&w_flags_next) r_state <= ST_EVAL;
          end
          ST_EVAL: begin
            if (w_hit_any) begin
              r_tx    <= '{hash: w_win_hash, nonce: w_win_nonce};
              r_send  <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_next_base[NONCE_W]) begin
              r_exh   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_base  <= w_next_base;
              r_flags <= '0;
              r_start <= '1;
              r_nonce <= lanes(w_next_base[NONCE_W-1:0]);
              r_state <= ST_DISPATCH;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign core.core_header = r_header;
  assign core.core_start  = r_start;
  assign core.core_nonce  = r_nonce;
  assign core.core_abort  = r_abort;
  assign tx_data          = r_tx;
  assign send_data        = r_send;
  assign exhausted        = r_exh;
  assign busy             = (r_state != ST_IDLE);

endmodule
